if_fetch_unit: RTL and testbench

Instruction fetch unit: owns the program counter, issues in-order requests to instruction memory, and pairs each returned word with its PC. It sits at the producer end of the IF/ID pipeline register and drives that register's PC/instruction/valid inputs. It takes the register's stall as backpressure and the pipeline redirect as flush. At most two fetches are in flight or buffered, and stale responses after a redirect are discarded.

---
 rtl/if_pkg.sv | 17 +
 rtl/fetch_buf.sv | 52 +++++
 rtl/if_fetch_unit.sv | 113 +++++++++++
 tb/tb_if_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch unit
package if_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } fetch_state_t;

    localparam int MAX_INFLIGHT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry synchronous FIFO with flush, used for in-flight PCs and fetched words
module fetch_buf
    import if_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] mem [MAX_INFLIGHT];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = i_pop && (o_count != 2'd0);
    // On a full FIFO a simultaneous pop frees the slot being written.
    assign do_push = i_push && ((o_count != 2'(MAX_INFLIGHT)) || do_pop);
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            o_count <= 2'd0;
        end else if (i_flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            o_count <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            o_count <= o_count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit: PC, in-order imem requests, IF/ID output buffer
// Optional feature: IF_FETCH_BYPASS_EN forwards a response to the outputs when the buffer is empty.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [1:0]   outstanding;
    logic [1:0]   discard, discard_nxt;
    logic [1:0]   pcq_count, buf_count;
    logic [31:0]  pcq_head;
    logic [$bits(fetch_entry_t)-1:0] buf_out;
    fetch_entry_t buf_in, buf_head;
    logic         gnt_acc, rsp_keep, buf_valid, buf_push, buf_pop, consume;

    assign buf_valid = (buf_count != 2'd0);
    assign rsp_keep  = (state == FETCH) && i_imem_rvalid && !i_redirect;
    assign consume   = o_valid && !i_stall && !i_redirect;
    assign buf_pop   = consume && buf_valid;
    // In FETCH the PC queue depth equals the outstanding count; a head leaving now frees its slot.
    assign o_imem_req = (state == FETCH) && !i_redirect &&
        (({1'b0, pcq_count} + {1'b0, buf_count} - 3'(consume)) < 3'(MAX_INFLIGHT));
    assign o_imem_addr = pc;
    assign gnt_acc     = o_imem_req && i_imem_gnt;
    assign buf_in      = '{pc: pcq_head, inst: i_imem_rdata};
    assign buf_head    = fetch_entry_t'(buf_out);

`ifdef IF_FETCH_BYPASS_EN
    logic bypass;
    assign bypass   = rsp_keep && !buf_valid;
    assign buf_push = rsp_keep && (buf_valid || i_stall);
    assign o_valid  = buf_valid || bypass;
    assign o_pc     = bypass ? pcq_head : buf_head.pc;
    assign o_inst   = bypass ? i_imem_rdata : buf_head.inst;
`else
    assign buf_push = rsp_keep;
    assign o_valid  = buf_valid;
    assign o_pc     = buf_head.pc;
    assign o_inst   = buf_head.inst;
`endif

    fetch_buf #(.WIDTH(32)) u_pc_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (gnt_acc),
        .i_data  (pc),
        .i_pop   (rsp_keep),
        .o_data  (pcq_head),
        .o_count (pcq_count)
    );

    fetch_buf #(.WIDTH($bits(fetch_entry_t))) u_out_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (buf_push),
        .i_data  (buf_in),
        .i_pop   (buf_pop),
        .o_data  (buf_out),
        .o_count (buf_count)
    );

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard - 2'((state == DRAIN) && i_imem_rvalid);
        if (i_redirect) begin
            discard_nxt = outstanding - 2'(i_imem_rvalid);
        end
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (i_redirect && (discard_nxt != 2'd0)) state_nxt = DRAIN;
            DRAIN:   if (discard_nxt == 2'd0) state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            outstanding <= outstanding + 2'(gnt_acc) - 2'(i_imem_rvalid);
            if (i_redirect) begin
                pc <= i_redirect_pc & ~32'h3;
            end else if (gnt_acc) begin
                pc <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid, stall, redirect, valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, pc, inst;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_pc          (pc),
        .o_inst        (inst),
        .o_valid       (valid)
    );

    typedef struct { logic [31:0] addr; int due; } mem_rsp_t;

    mem_rsp_t     mem_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  gnt_addr[$];
    int           gnt_cyc[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           stale = 0;
    int           lat = 1;
    int           first_valid = -1;
    logic         boot = 1'b0;
    logic         hold_chk = 1'b0;
    logic [31:0]  exp_addr = RST_PC;
    logic [31:0]  hold_pc = '0;
    logic [31:0]  hold_inst = '0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, check after settling, update the model.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic g);
        logic rv, consume, exp_req;
        int   pending, due;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        rv          = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? inst_of(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        if (hold_chk) begin
            check_eq("hold_valid", valid, 1'b1);
            check_eq("hold_pc", pc, hold_pc);
            check_eq("hold_inst", inst, hold_inst);
        end
        if (valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", valid, 1'b0);
            end else begin
                check_eq("out_pc", pc, exp_q[0].pc);
                check_eq("out_inst", inst, exp_q[0].inst);
            end
            if (first_valid < 0) first_valid = cyc;
        end
        consume = valid && !st && !rd && (exp_q.size() > 0);
        pending = exp_q.size() - (consume ? 1 : 0);
        exp_req = !boot && (stale == 0) && !rd && (pending < MAX_INFLIGHT);
        check_eq("imem_req", imem_req, exp_req);
        if (imem_req) check_eq("imem_addr", imem_addr, exp_addr);
        hold_chk  = valid && st && !rd;
        hold_pc   = pc;
        hold_inst = inst;
        if (consume) void'(exp_q.pop_front());
        if (rv) begin
            void'(mem_q.pop_front());
            if (stale > 0) stale--;
        end
        if (rd) begin
            stale    = mem_q.size();
            exp_q.delete();
            exp_addr = rpc & ~32'h3;
        end else if (imem_req && g) begin
            due = cyc + lat;
            if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
            mem_q.push_back('{imem_addr, due});
            exp_q.push_back('{pc: imem_addr, inst: inst_of(imem_addr)});
            gnt_addr.push_back(imem_addr);
            gnt_cyc.push_back(cyc);
            exp_addr = imem_addr + 32'd4;
        end
        check_eq("capacity", 32'(exp_q.size() <= MAX_INFLIGHT), 1'b1);
        boot = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int tries, n0;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_addr", imem_addr, RST_PC);
        rst_n = 1'b1;
        boot  = 1'b1;

        // Streaming with 1-cycle memory, address wrap at the top of memory
        lat = 1;
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
        if (gnt_addr.size() < 3) begin
            check_eq("gnt_count", gnt_addr.size(), 3);
        end else begin
            check_eq("addr0", gnt_addr[0], 32'hFFFF_FFF8);
            check_eq("addr1", gnt_addr[1], 32'hFFFF_FFFC);
            check_eq("addr2", gnt_addr[2], 32'h0000_0000);
            check_eq("gnt_back_to_back", gnt_cyc[2] - gnt_cyc[0], 2);
`ifdef IF_FETCH_BYPASS_EN
            check_eq("gnt_to_valid", first_valid - gnt_cyc[0], 1);
`else
            check_eq("gnt_to_valid", first_valid - gnt_cyc[0], 2);
`endif
        end

        // Stall three cycles, then release
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("stall_req_low", imem_req, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with two requests outstanding and no response in that cycle
        lat = 3;
        tries = 0;
        while (!(mem_q.size() == 2 && mem_q[0].due > cyc) && tries < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            tries++;
        end
        check_eq("setup_two_outstanding", mem_q.size(), 2);
        step(1'b0, 1'b1, 32'h0000_1003, 1'b1);
        n0 = gnt_addr.size();
        tries = 0;
        while (gnt_addr.size() == n0 && tries < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            tries++;
        end
        check_eq("redir_target", (gnt_addr.size() > n0) ? gnt_addr[$] : 32'hFFFF_FFFF, 32'h0000_1000);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect together with a response and a stall
        lat = 2;
        tries = 0;
        while (!(mem_q.size() == 2 && mem_q[0].due <= cyc) && tries < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            tries++;
        end
        check_eq("setup_rvalid_redirect", mem_q.size(), 2);
        step(1'b1, 1'b1, 32'h0000_2002, 1'b1);
        check_eq("valid_after_redirect", valid, 1'b0);
        n0 = gnt_addr.size();
        tries = 0;
        while (gnt_addr.size() == n0 && tries < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            tries++;
        end
        check_eq("redir2_target", (gnt_addr.size() > n0) ? gnt_addr[$] : 32'hFFFF_FFFF, 32'h0000_2000);

        // Random stall, grant, latency and redirect mix
        repeat (80) begin
            lat = $urandom_range(1, 3);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        tries = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && tries < 30) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            tries++;
        end
        check_eq("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
